// File: rtl/barret_rr_sched_3259_pkg.sv
// Shared constants for the q = 3259 Barrett reduction scheduler.
package barret_rr_sched_3259_pkg;
   localparam int unsigned Q      = 3259;
   localparam int unsigned MU     = 5147;
   localparam int unsigned SHIFT  = 12;
   localparam int unsigned DIN_W  = 23;
   localparam int unsigned DOUT_W = 12;
endpackage

// File: rtl/barret_rr_sched_3259_pipe.sv
// Three-stage Barrett reducer for q = 3259 carrying a valid bit and a requester tag.
module barret_pipe_3259
   import barret_rr_sched_3259_pkg::*;
#(
   parameter int unsigned ID_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ID_W-1:0]   in_id,
   input  logic [DIN_W-1:0]  in_data,
   output logic              out_valid,
   output logic [ID_W-1:0]   out_id,
   output logic [DOUT_W-1:0] out_data
);
   localparam int unsigned Q2_W = 24;
   localparam int unsigned T_W  = 12;
   localparam int unsigned R_W  = 14;
   localparam logic [R_W-1:0] Q_R = R_W'(Q);

   logic [2:0]        vld;
   logic [ID_W-1:0]   id_s1, id_s2, id_s3;
   logic [DIN_W-1:0]  din_s1;
   logic [T_W-1:0]    t_s1;
   logic [R_W-1:0]    r_s2;
   logic [DOUT_W-1:0] res_s3;

   logic [T_W-1:0]    t_c;
   logic [R_W-1:0]    r_c;
   logic [R_W-1:0]    r_a_c;
   logic [DOUT_W-1:0] res_c;

   // Quotient estimate undershoots by at most 2, so two corrections give the exact residue.
   always_comb begin
      t_c   = T_W'((Q2_W'(in_data[DIN_W-1:SHIFT]) * Q2_W'(MU)) >> SHIFT);
      r_c   = R_W'(din_s1 - DIN_W'(t_s1) * DIN_W'(Q));
      r_a_c = (r_s2 >= Q_R) ? r_s2 - Q_R : r_s2;
      res_c = DOUT_W'((r_a_c >= Q_R) ? r_a_c - Q_R : r_a_c);
   end

   always_ff @(posedge clk) begin
      if (rst) vld <= '0;
      else     vld <= {vld[1:0], in_valid};
   end

   always_ff @(posedge clk) begin
      id_s1  <= in_id;
      din_s1 <= in_data;
      t_s1   <= t_c;
      id_s2  <= id_s1;
      r_s2   <= r_c;
      id_s3  <= id_s2;
      res_s3 <= res_c;
   end

   assign out_valid = vld[2];
   assign out_id    = id_s3;
   assign out_data  = res_s3;
endmodule

// File: rtl/barret_rr_sched_3259.sv
// Round-robin shared Barrett reducer: credit-guarded issue, in-order tagged result FIFO.
module barret_rr_sched_3259
   import barret_rr_sched_3259_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PIPE_STAGES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*DIN_W-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DOUT_W-1:0]      rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < PIPE_STAGES + 1) begin : g_bad_depth
      $error("FIFO_DEPTH too small to cover the reducer pipeline");
   end

   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  out_cnt;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [DOUT_W-1:0] fifo_data [FIFO_DEPTH];
   logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];

   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic              credit_ok;
   logic              issue;
   logic              pop;
   logic              push;
   logic [ID_W-1:0]   push_id;
   logic [DOUT_W-1:0] push_data;

   assign pop       = rsp_valid & rsp_ready;
   assign credit_ok = !rst && ((out_cnt < CNT_W'(FIFO_DEPTH)) || pop);

   // First asserted requester at or after rr_ptr, wrapping at N_REQ.
   always_comb begin : arb_p
      logic [ID_W-1:0] idx;
      idx         = rr_ptr;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
         idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
      end
   end

   always_comb begin
      req_ready = '0;
      if (credit_ok && grant_found) req_ready[grant_id] = 1'b1;
   end

   assign issue = credit_ok & grant_found;

   barret_pipe_3259 #(.ID_W(ID_W)) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (issue),
      .in_id     (grant_id),
      .in_data   (req_data[grant_id*DIN_W +: DIN_W]),
      .out_valid (push),
      .out_id    (push_id),
      .out_data  (push_data)
   );

   // Outstanding credit covers both the pipeline and the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         out_cnt <= '0;
      end else begin
         if (issue) rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         out_cnt <= out_cnt + CNT_W'(issue) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_id[i]   <= '0;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_id[wr_ptr]   <= push_id;
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign rsp_valid = (fifo_cnt != '0);
   assign rsp_data  = fifo_data[rd_ptr];
   assign rsp_id    = fifo_id[rd_ptr];
   assign busy      = (out_cnt != '0);
endmodule

// File: tb/tb_barret_rr_sched_3259.sv
// Directed and random checks of the scheduler against a queue-based reference model.
module tb_barret_rr_sched_3259;
   localparam int N  = 4;
   localparam int QV = 3259;
   localparam int LAT = 4;
   localparam int CREDITS = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*23-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [11:0]     rsp_data;
   logic [1:0]      rsp_id;
   logic            busy;

   barret_rr_sched_3259 dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned data;
      int unsigned id;
      int          due;
   } exp_t;

   exp_t        model_q[$];
   int          rr;
   int          cyc;
   int          checks;
   int          errors;
   int unsigned got_data[$];
   int          got_cyc[$];
   int          grants[$];
   int          accepted;
   int          t_start;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [22:0] rnd_din();
      case ($urandom_range(0, 7))
         0:       return 23'd0;
         1:       return 23'h7FFFFF;
         2:       return 23'(QV * $urandom_range(0, 2573));
         3:       return 23'(QV * $urandom_range(1, 2573) - 1);
         default: return 23'($urandom);
      endcase
   endfunction

   // One clock: check outputs late in the cycle, then advance the model across the edge.
   task automatic cycle();
      bit          exp_rv, pop, credit, found;
      int          g;
      logic [N-1:0] exp_rdy;
      int unsigned din;
      #3;
      exp_rv = (model_q.size() != 0) && (model_q[0].due <= cyc);
      pop    = exp_rv && rsp_ready;
      credit = !rst && ((model_q.size() - int'(pop)) < CREDITS);
      found  = 1'b0;
      g      = 0;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (rr + k) % N;
         if (!found && req_valid[i]) begin
            found = 1'b1;
            g     = i;
         end
      end
      exp_rdy = '0;
      if (found && credit) exp_rdy[g] = 1'b1;

      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(model_q.size() != 0));
      if (exp_rv) begin
         chk("rsp_data", 32'(rsp_data), model_q[0].data);
         chk("rsp_id", 32'(rsp_id), model_q[0].id);
      end

      if (rsp_valid && rsp_ready) begin
         got_data.push_back(32'(rsp_data));
         got_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            accepted++;
            grants.push_back(i);
         end
      end

      if (rst) begin
         model_q.delete();
         rr = 0;
      end else begin
         if (pop) void'(model_q.pop_front());
         if (found && credit) begin
            din = 32'(req_data[g*23 +: 23]);
            model_q.push_back('{data: din % QV, id: g, due: cyc + LAT});
            rr = (g + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic clear_obs();
      got_data.delete();
      got_cyc.delete();
      grants.delete();
      accepted = 0;
   endtask

   initial begin
      int unsigned t2_in [4];
      int unsigned t2_exp[4];
      t2_in  = '{0, 3259, 6517, 8388607};
      t2_exp = '{0, 0, 3258, 3200};
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      rr        = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      cycle();

      // Single operation latency and value
      clear_obs();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      req_data[0 +: 23] = 23'd10000;
      t_start = cyc;
      cycle();
      req_valid = '0;
      repeat (7) cycle();
      chk("t1_count", 32'(got_data.size()), 1);
      if (got_data.size() == 1) begin
         chk("t1_data", got_data[0], 223);
         chk("t1_latency", 32'(got_cyc[0] - t_start), LAT);
      end

      // Edge operands from requester 1
      clear_obs();
      req_valid = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         req_data[23 +: 23] = 23'(t2_in[k]);
         cycle();
      end
      req_valid = '0;
      repeat (8) cycle();
      chk("t2_count", 32'(got_data.size()), 4);
      if (got_data.size() == 4)
         for (int k = 0; k < 4; k++) chk("t2_data", got_data[k], t2_exp[k]);

      // Fairness with continuous requests
      reset_pulse();
      clear_obs();
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i*23 +: 23] = rnd_din();
      repeat (12) cycle();
      chk("t3_grants", 32'(grants.size()), 12);
      if (grants.size() == 12)
         for (int k = 0; k < 12; k++) chk("t3_order", 32'(grants[k]), 32'(k % N));
      req_valid = '0;
      repeat (8) cycle();
      chk("t3_rsp_count", 32'(got_data.size()), 12);

      // Backpressure fills the credit window, then same-cycle pop restarts issue
      clear_obs();
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      repeat (8) cycle();
      chk("t4_accepted", 32'(accepted), CREDITS);
      chk("t4_ready_blocked", 32'(req_ready), 0);
      rsp_ready = 1'b1;
      repeat (10) cycle();
      req_valid = '0;
      repeat (8) cycle();
      chk("t4_rsp_count", 32'(got_data.size()), 32'(accepted));

      // Reset with operations in flight
      reset_pulse();
      clear_obs();
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      repeat (3) begin
         req_data[46 +: 23] = rnd_din();
         cycle();
      end
      req_valid = '0;
      reset_pulse();
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_rsp_data", 32'(rsp_data), 0);
      req_valid = 4'b1111;
      #1;
      chk("t5_grant", 32'(req_ready), 32'(4'b0001));
      cycle();
      req_valid = '0;
      clear_obs();
      repeat (8) cycle();
      chk("t5_only_new", 32'(got_data.size()), 1);

      // Random traffic against the model
      for (int n = 0; n < 10000; n++) begin
         req_valid = 4'($urandom);
         for (int i = 0; i < N; i++) req_data[i*23 +: 23] = rnd_din();
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (10) cycle();
      chk("final_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
